// File: rtl/d_format_decoder_pkg.sv
// Shared constants and types for the D-form decode stage.
//   - field widths of the instruction record
//   - register access pattern codes (read = 2'b10, write = 2'b01)
//   - functional unit codes
//   - one-hot format code that selects the D-form decoder
//   - d_attr_t: per-opcode attributes produced by d_form_opcode_table
//   - dec_rec_t: the registered decoded-instruction record
package d_format_decoder_pkg;

   localparam int ADDR_W    = 64;
   localparam int INSTR_W   = 32;
   localparam int PID_W     = 20;
   localparam int TID_W     = 16;
   localparam int MAJ_ID_W  = 64;
   localparam int MIN_ID_W  = 7;
   localparam int OPCODE_W  = 12;
   localparam int PRIM_OP_W = 6;
   localparam int REG_W     = 5;
   localparam int IMM_W     = 16;
   localparam int RW_W      = 2;
   localparam int FU_W      = 3;
   localparam int FMT_W     = 25;
   localparam int BODY_W    = 2 * REG_W + IMM_W;

   localparam logic [RW_W-1:0] REG_NONE  = 2'b00;
   localparam logic [RW_W-1:0] REG_READ  = 2'b10;
   localparam logic [RW_W-1:0] REG_WRITE = 2'b01;
   localparam logic [RW_W-1:0] REG_RW    = 2'b11;

   localparam logic [FU_W-1:0] FU_FX     = 3'd0;
   localparam logic [FU_W-1:0] FU_FP     = 3'd1;
   localparam logic [FU_W-1:0] FU_VX     = 3'd2;
   localparam logic [FU_W-1:0] FU_CR     = 3'd3;
   localparam logic [FU_W-1:0] FU_LS     = 3'd4;
   localparam logic [FU_W-1:0] FU_BRANCH = 3'd6;

   localparam logic [FMT_W-1:0] FMT_D = 25'd32;

   // Instance tag only; carries no function.
   localparam int D_DECODER_INSTANCE = 0;

   typedef struct packed {
      logic            valid;
      logic [FU_W-1:0] unit;
      logic [RW_W-1:0] op1rw;
      logic [RW_W-1:0] op2rw;
      logic            op1_is_reg;
      logic            op2_is_reg;
      logic            imm_ext;
      logic            imm_shf;
   } d_attr_t;

   typedef struct packed {
      logic [OPCODE_W-1:0] opcode;
      logic [ADDR_W-1:0]   addr;
      logic [FU_W-1:0]     unit;
      logic [MAJ_ID_W-1:0] maj_id;
      logic [MIN_ID_W-1:0] min_id;
      logic [MIN_ID_W-1:0] num_uops;
      logic                is64;
      logic [PID_W-1:0]    pid;
      logic [TID_W-1:0]    tid;
      logic [RW_W-1:0]     op1rw;
      logic [RW_W-1:0]     op2rw;
      logic                op1_is_reg;
      logic                op2_is_reg;
      logic                imm_ext;
      logic                imm_shf;
      logic [BODY_W-1:0]   body;
   } dec_rec_t;

endpackage

// File: rtl/d_format_decoder_opcode_table.sv
// d_form_opcode_table: combinational attribute lookup for D-form primary opcodes.
// Ports:
//   prim_opcode_i [6] : primary opcode
//   ra_i          [5] : RA field (RA==0 means literal zero, not a register)
//   attr_o            : {valid, unit, op1rw, op2rw, op1isReg, op2isReg, immExt, immShf}
module d_form_opcode_table
   import d_format_decoder_pkg::*;
(
   input  logic [PRIM_OP_W-1:0] prim_opcode_i,
   input  logic [REG_W-1:0]     ra_i,
   output d_attr_t              attr_o
);

   logic ra_nz;
   assign ra_nz = (ra_i != '0);

   always_comb begin
      attr_o            = '0;
      attr_o.op1_is_reg = 1'b1;
      attr_o.op2_is_reg = 1'b1;
      attr_o.op2rw      = REG_READ;
      attr_o.imm_ext    = 1'b1;
      case (prim_opcode_i)
         // tdi, twi: op1 is the TO field
         6'd2, 6'd3: begin
            attr_o.valid      = 1'b1;
            attr_o.unit       = FU_BRANCH;
            attr_o.op1_is_reg = 1'b0;
         end
         6'd7, 6'd8, 6'd12, 6'd13: begin
            attr_o.valid = 1'b1;
            attr_o.unit  = FU_FX;
            attr_o.op1rw = REG_WRITE;
         end
         // cmpli (unsigned imm), cmpi: op1 is BF/L
         6'd10, 6'd11: begin
            attr_o.valid      = 1'b1;
            attr_o.unit       = FU_FX;
            attr_o.op1_is_reg = 1'b0;
            attr_o.imm_ext    = prim_opcode_i[0];
         end
         6'd14, 6'd15: begin
            attr_o.valid      = 1'b1;
            attr_o.unit       = FU_FX;
            attr_o.op1rw      = REG_WRITE;
            attr_o.op2_is_reg = ra_nz;
            attr_o.imm_shf    = prim_opcode_i[0];
         end
         // logical immediates: RS is read, RA is written; odd opcodes are the "s" forms
         6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29: begin
            attr_o.valid   = 1'b1;
            attr_o.unit    = FU_FX;
            attr_o.op1rw   = REG_READ;
            attr_o.op2rw   = REG_WRITE;
            attr_o.imm_ext = 1'b0;
            attr_o.imm_shf = prim_opcode_i[0];
         end
         6'd32, 6'd34, 6'd40, 6'd42, 6'd46, 6'd48, 6'd50: begin
            attr_o.valid      = 1'b1;
            attr_o.unit       = FU_LS;
            attr_o.op1rw      = REG_WRITE;
            attr_o.op2_is_reg = ra_nz;
         end
         6'd33, 6'd35, 6'd41, 6'd43, 6'd49, 6'd51: begin
            attr_o.valid = 1'b1;
            attr_o.unit  = FU_LS;
            attr_o.op1rw = REG_WRITE;
            attr_o.op2rw = REG_RW;
         end
         6'd36, 6'd38, 6'd44, 6'd47, 6'd52, 6'd54: begin
            attr_o.valid      = 1'b1;
            attr_o.unit       = FU_LS;
            attr_o.op1rw      = REG_READ;
            attr_o.op2_is_reg = ra_nz;
         end
         6'd37, 6'd39, 6'd45, 6'd53, 6'd55: begin
            attr_o.valid = 1'b1;
            attr_o.unit  = FU_LS;
            attr_o.op1rw = REG_READ;
            attr_o.op2rw = REG_RW;
         end
         default: attr_o.valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/d_format_decoder.sv
// d_format_decoder: D-form decode stage with a one-cycle pipeline register.
// Ports:
//   clock_i, reset_i (sync, active-high), enable_i (input valid), stall_i (hold)
//   instFormat_i, instructionOpcode_i, instruction_i and per-instruction tags in
//   enable_o plus the registered decoded record out (opcode, unit, IDs, operand
//   access patterns, immediate flags, raw operand body)
// Non-accepted inputs clear enable_o but leave the rest of the record as it was.
module d_format_decoder
   import d_format_decoder_pkg::*;
(
   input  logic                 clock_i,
   input  logic                 reset_i,
   input  logic                 enable_i,
   input  logic                 stall_i,
   input  logic [FMT_W-1:0]     instFormat_i,
   input  logic [PRIM_OP_W-1:0] instructionOpcode_i,
   input  logic [INSTR_W-1:0]   instruction_i,
   input  logic [ADDR_W-1:0]    instructionAddress_i,
   input  logic                 is64Bit_i,
   input  logic [PID_W-1:0]     instructionPid_i,
   input  logic [TID_W-1:0]     instructionTid_i,
   input  logic [MAJ_ID_W-1:0]  instructionMajId_i,
   output logic                 enable_o,
   output logic [OPCODE_W-1:0]  opcode_o,
   output logic [ADDR_W-1:0]    instructionAddress_o,
   output logic [FU_W-1:0]      functionalUnitType_o,
   output logic [MAJ_ID_W-1:0]  instMajId_o,
   output logic [MIN_ID_W-1:0]  instMinId_o,
   output logic [MIN_ID_W-1:0]  numMicroOps_o,
   output logic                 is64Bit_o,
   output logic [PID_W-1:0]     instPid_o,
   output logic [TID_W-1:0]     instTid_o,
   output logic [RW_W-1:0]      op1rw_o,
   output logic [RW_W-1:0]      op2rw_o,
   output logic                 op1isReg_o,
   output logic                 op2isReg_o,
   output logic                 immIsExtended_o,
   output logic                 immIsShifted_o,
   output logic [BODY_W-1:0]    instructionBody_o
);

   d_attr_t  attr;
   dec_rec_t rec_d, rec_q;
   logic     enable_q;
   logic     accept;

   // Big-endian bits [0:5] (primary opcode) are supplied separately on
   // instructionOpcode_i; the word's own copy is not needed here.
   logic unused_prim_bits;
   assign unused_prim_bits = ^instruction_i[31:26];

   // Big-endian [11:15] is RA, i.e. little-endian [20:16].
   d_form_opcode_table u_table (
      .prim_opcode_i (instructionOpcode_i),
      .ra_i          (instruction_i[20:16]),
      .attr_o        (attr)
   );

   assign accept = enable_i && (instFormat_i == FMT_D) && attr.valid;

   always_comb begin
      rec_d            = '0;
      rec_d.opcode     = {instructionOpcode_i, 6'b0};
      rec_d.addr       = instructionAddress_i;
      rec_d.unit       = attr.unit;
      rec_d.maj_id     = instructionMajId_i;
      rec_d.min_id     = '0;
      rec_d.num_uops   = 7'd1;
      rec_d.is64       = is64Bit_i;
      rec_d.pid        = instructionPid_i;
      rec_d.tid        = instructionTid_i;
      rec_d.op1rw      = attr.op1rw;
      rec_d.op2rw      = attr.op2rw;
      rec_d.op1_is_reg = attr.op1_is_reg;
      rec_d.op2_is_reg = attr.op2_is_reg;
      rec_d.imm_ext    = attr.imm_ext;
      rec_d.imm_shf    = attr.imm_shf;
      rec_d.body       = instruction_i[BODY_W-1:0];
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         enable_q <= 1'b0;
         rec_q    <= '0;
      end else if (!stall_i) begin
         enable_q <= accept;
         if (accept) rec_q <= rec_d;
      end
   end

   assign enable_o             = enable_q;
   assign opcode_o             = rec_q.opcode;
   assign instructionAddress_o = rec_q.addr;
   assign functionalUnitType_o = rec_q.unit;
   assign instMajId_o          = rec_q.maj_id;
   assign instMinId_o          = rec_q.min_id;
   assign numMicroOps_o        = rec_q.num_uops;
   assign is64Bit_o            = rec_q.is64;
   assign instPid_o            = rec_q.pid;
   assign instTid_o            = rec_q.tid;
   assign op1rw_o              = rec_q.op1rw;
   assign op2rw_o              = rec_q.op2rw;
   assign op1isReg_o           = rec_q.op1_is_reg;
   assign op2isReg_o           = rec_q.op2_is_reg;
   assign immIsExtended_o      = rec_q.imm_ext;
   assign immIsShifted_o       = rec_q.imm_shf;
   assign instructionBody_o    = rec_q.body;

endmodule

// File: tb/tb_d_format_decoder.sv
module tb_d_format_decoder;

   logic        clock_i = 1'b0;
   logic        reset_i, enable_i, stall_i, is64Bit_i;
   logic [24:0] instFormat_i;
   logic [5:0]  instructionOpcode_i;
   logic [31:0] instruction_i;
   logic [63:0] instructionAddress_i, instructionMajId_i;
   logic [19:0] instructionPid_i;
   logic [15:0] instructionTid_i;

   logic        enable_o, is64Bit_o, op1isReg_o, op2isReg_o, immIsExtended_o, immIsShifted_o;
   logic [11:0] opcode_o;
   logic [63:0] instructionAddress_o, instMajId_o;
   logic [2:0]  functionalUnitType_o;
   logic [6:0]  instMinId_o, numMicroOps_o;
   logic [19:0] instPid_o;
   logic [15:0] instTid_o;
   logic [1:0]  op1rw_o, op2rw_o;
   logic [25:0] instructionBody_o;

   d_format_decoder dut (
      .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i), .stall_i(stall_i),
      .instFormat_i(instFormat_i), .instructionOpcode_i(instructionOpcode_i),
      .instruction_i(instruction_i), .instructionAddress_i(instructionAddress_i),
      .is64Bit_i(is64Bit_i), .instructionPid_i(instructionPid_i),
      .instructionTid_i(instructionTid_i), .instructionMajId_i(instructionMajId_i),
      .enable_o(enable_o), .opcode_o(opcode_o), .instructionAddress_o(instructionAddress_o),
      .functionalUnitType_o(functionalUnitType_o), .instMajId_o(instMajId_o),
      .instMinId_o(instMinId_o), .numMicroOps_o(numMicroOps_o), .is64Bit_o(is64Bit_o),
      .instPid_o(instPid_o), .instTid_o(instTid_o), .op1rw_o(op1rw_o), .op2rw_o(op2rw_o),
      .op1isReg_o(op1isReg_o), .op2isReg_o(op2isReg_o), .immIsExtended_o(immIsExtended_o),
      .immIsShifted_o(immIsShifted_o), .instructionBody_o(instructionBody_o)
   );

   always #5 clock_i = ~clock_i;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
   endtask

   // Reference model: expected registered state
   logic        e_en, e_64, e_op1r, e_op2r, e_ext, e_shf;
   logic [11:0] e_opc;
   logic [63:0] e_addr, e_maj;
   logic [2:0]  e_unit;
   logic [6:0]  e_min, e_nmo;
   logic [19:0] e_pid;
   logic [15:0] e_tid;
   logic [1:0]  e_op1rw, e_op2rw;
   logic [25:0] e_body;

   task automatic model_step();
      int  op, base;
      bit  upd, load, ra_zero, valid;
      op      = int'(instructionOpcode_i);
      ra_zero = (instruction_i[20:16] == 5'd0);
      valid   = enable_i && instFormat_i == 25'd32 &&
                (op inside {2, 3, 7, 8, [10:15], [24:29], [32:55]});
      if (reset_i) begin
         {e_en, e_64, e_op1r, e_op2r, e_ext, e_shf} = '0;
         e_opc = '0; e_addr = '0; e_maj = '0; e_unit = '0; e_min = '0; e_nmo = '0;
         e_pid = '0; e_tid = '0; e_op1rw = '0; e_op2rw = '0; e_body = '0;
      end else if (!stall_i) begin
         e_en = valid;
         if (valid) begin
            e_opc  = 12'(op * 64);
            e_addr = instructionAddress_i; e_maj = instructionMajId_i;
            e_min  = 0; e_nmo = 1; e_64 = is64Bit_i;
            e_pid  = instructionPid_i; e_tid = instructionTid_i;
            e_body = instruction_i[25:0];
            e_op1r = 1; e_op2r = 1; e_shf = 0; e_ext = 1; e_op2rw = 2'b10;
            if (op inside {2, 3}) begin
               e_unit = 6; e_op1r = 0; e_op1rw = 2'b00;
            end else if (op inside {7, 8, 12, 13}) begin
               e_unit = 0; e_op1rw = 2'b01;
            end else if (op inside {10, 11}) begin
               e_unit = 0; e_op1r = 0; e_op1rw = 2'b00; e_ext = (op == 11);
            end else if (op inside {14, 15}) begin
               e_unit = 0; e_op1rw = 2'b01; e_op2r = !ra_zero; e_shf = (op == 15);
            end else if (op inside {[24:29]}) begin
               e_unit = 0; e_op1rw = 2'b10; e_op2rw = 2'b01; e_ext = 0;
               e_shf = (op inside {25, 27, 29});
            end else begin
               upd  = (op inside {33, 35, 37, 39, 41, 43, 45, 49, 51, 53, 55});
               base = upd ? op - 1 : op;
               load = (base inside {32, 34, 40, 42, 46, 48, 50});
               e_unit  = 4;
               e_op1rw = load ? 2'b01 : 2'b10;
               e_op2rw = upd ? 2'b11 : 2'b10;
               e_op2r  = upd ? 1'b1 : !ra_zero;
            end
         end
      end
   endtask

   task automatic check_all(input string pfx);
      check({pfx, ".enable"}, 64'(enable_o), 64'(e_en));
      check({pfx, ".opcode"}, 64'(opcode_o), 64'(e_opc));
      check({pfx, ".addr"}, instructionAddress_o, e_addr);
      check({pfx, ".unit"}, 64'(functionalUnitType_o), 64'(e_unit));
      check({pfx, ".majid"}, instMajId_o, e_maj);
      check({pfx, ".minid"}, 64'(instMinId_o), 64'(e_min));
      check({pfx, ".nuops"}, 64'(numMicroOps_o), 64'(e_nmo));
      check({pfx, ".is64"}, 64'(is64Bit_o), 64'(e_64));
      check({pfx, ".pid"}, 64'(instPid_o), 64'(e_pid));
      check({pfx, ".tid"}, 64'(instTid_o), 64'(e_tid));
      check({pfx, ".op1rw"}, 64'(op1rw_o), 64'(e_op1rw));
      check({pfx, ".op2rw"}, 64'(op2rw_o), 64'(e_op2rw));
      check({pfx, ".op1reg"}, 64'(op1isReg_o), 64'(e_op1r));
      check({pfx, ".op2reg"}, 64'(op2isReg_o), 64'(e_op2r));
      check({pfx, ".immext"}, 64'(immIsExtended_o), 64'(e_ext));
      check({pfx, ".immshf"}, 64'(immIsShifted_o), 64'(e_shf));
      check({pfx, ".body"}, 64'(instructionBody_o), 64'(e_body));
   endtask

   task automatic tick(input string pfx);
      model_step();
      @(posedge clock_i);
      #1;
      check_all(pfx);
   endtask

   task automatic set_instr(input int op, input int rt, input int ra, input int imm);
      instructionOpcode_i = 6'(op);
      instruction_i       = {6'(op), 5'(rt), 5'(ra), 16'(imm)};
   endtask

   task automatic rand_tags();
      instructionAddress_i = {$urandom, $urandom};
      instructionMajId_i   = {$urandom, $urandom};
      instructionPid_i     = 20'($urandom);
      instructionTid_i     = 16'($urandom);
      is64Bit_i            = 1'($urandom);
   endtask

   int n_en;

   initial begin
      reset_i = 1; enable_i = 0; stall_i = 0; instFormat_i = 25'd32;
      set_instr(0, 0, 0, 0);
      rand_tags();
      tick("reset");
      reset_i = 0;

      // opcode sweep, RA=0, imm=0
      n_en = 0;
      for (int op = 0; op < 64; op++) begin
         enable_i = 1; set_instr(op, op % 32, 0, 0); rand_tags();
         tick("sweep");
         if (enable_o) n_en++;
      end
      check("sweep.count", 64'(n_en), 64'd40);

      // addis RT=3 RA=4 imm=0x1234
      set_instr(15, 3, 4, 16'h1234); rand_tags();
      tick("addis");
      check("addis.opcode_abs", 64'(opcode_o), 64'h3C0);
      check("addis.body_abs", 64'(instructionBody_o), 64'({5'd3, 5'd4, 16'h1234}));
      check("addis.shf_abs", 64'(immIsShifted_o), 64'd1);

      // not D-format: enable drops, record held
      instFormat_i = 25'h10; set_instr(14, 1, 2, 7); rand_tags();
      tick("notD");
      instFormat_i = 25'd32;

      // lwzu RA=5, then lwz RA=0
      set_instr(33, 6, 5, 8); rand_tags();
      tick("lwzu");
      check("lwzu.op2rw_abs", 64'(op2rw_o), 64'd3);
      set_instr(32, 6, 0, 8); rand_tags();
      tick("lwz_ra0");
      check("lwz.op2reg_abs", 64'(op2isReg_o), 64'd0);

      // stall holds everything, then releases
      stall_i = 1; set_instr(36, 9, 10, 16'hFFF0); rand_tags();
      tick("stall");
      tick("stall2");
      stall_i = 0;
      tick("unstall");

      // reset after valid decode
      set_instr(2, 4, 7, 3); rand_tags();
      tick("tdi");
      reset_i = 1; enable_i = 0;
      tick("reset2");
      reset_i = 0;

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         reset_i  = ($urandom_range(0, 49) == 0);
         stall_i  = ($urandom_range(0, 4) == 0);
         enable_i = ($urandom_range(0, 3) != 0);
         instFormat_i = ($urandom_range(0, 3) != 0) ? 25'd32 : (25'd1 << $urandom_range(0, 24));
         instruction_i       = $urandom;
         instructionOpcode_i = ($urandom_range(0, 1) == 1) ? instruction_i[31:26] : 6'($urandom);
         if ($urandom_range(0, 3) == 0) instruction_i[20:16] = 5'd0;
         rand_tags();
         tick("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
